// File: rtl/traffic_ctrl_sensor.sv
// traffic_ctrl_sensor: highway/country traffic-light controller with vehicle sensor,
// bounded country green, all-red clearance and night flash mode.
module traffic_ctrl_sensor #(
   parameter int CW       = 4,
   parameter int T_HG     = 6,
   parameter int T_HY     = 3,
   parameter int T_AR     = 1,
   parameter int T_CG_MIN = 2,
   parameter int T_CG_MAX = 8,
   parameter int T_CY     = 3,
   parameter int T_FL     = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          car_wait,
   input  logic          flash,
   output logic [CW-1:0] counter,
   output logic [2:0]    traffic_state,
   output logic          H_R,
   output logic          H_Y,
   output logic          H_G,
   output logic          C_R,
   output logic          C_Y,
   output logic          C_G
);
   typedef enum logic [2:0] {HG, HY, AR1, CG, CY, AR2, FL, BAD} state_t;
   localparam logic [CW-1:0] L_HG    = CW'(T_HG - 1);
   localparam logic [CW-1:0] L_HY    = CW'(T_HY - 1);
   localparam logic [CW-1:0] L_AR    = CW'(T_AR - 1);
   localparam logic [CW-1:0] L_CGMIN = CW'(T_CG_MIN - 1);
   localparam logic [CW-1:0] L_CGMAX = CW'(T_CG_MAX - 1);
   localparam logic [CW-1:0] L_CY    = CW'(T_CY - 1);
   localparam logic [CW-1:0] L_FL    = CW'(T_FL - 1);
   state_t        r_state, w_nxt, w_tgt;
   logic [CW-1:0] r_cnt, w_cnt;
   logic          r_phase, w_phase, w_done;
   logic [5:0]    r_lamps;
   // lamp vector order: {H_R, H_Y, H_G, C_R, C_Y, C_G}
   function automatic logic [5:0] lamps(state_t s, logic p);
      case (s)
         HY:       lamps = 6'b010100;
         AR1, AR2: lamps = 6'b100100;
         CG:       lamps = 6'b100001;
         CY:       lamps = 6'b100010;
         FL:       lamps = {1'b0, p, 2'b00, p, 1'b0};
         default:  lamps = 6'b001100;
      endcase
   endfunction
   always_comb begin
      w_done = 1'b1;
      w_tgt  = HG;
      case (r_state)
         HG:  begin w_done = (r_cnt == L_HG) && car_wait; w_tgt = HY; end
         HY:  begin w_done = r_cnt == L_HY; w_tgt = AR1; end
         AR1: begin w_done = r_cnt == L_AR; w_tgt = CG; end
         CG:  begin w_done = (r_cnt == L_CGMAX) || (r_cnt >= L_CGMIN && !car_wait); w_tgt = CY; end
         CY:  begin w_done = r_cnt == L_CY; w_tgt = AR2; end
         AR2: begin w_done = r_cnt == L_AR; w_tgt = HG; end
         FL:  w_tgt = AR2;
         default: w_tgt = HG;
      endcase
      w_nxt   = flash ? FL : (w_done ? w_tgt : r_state);
      w_phase = flash;
      w_cnt   = '0;
      if (flash && r_state == FL) begin
         w_cnt   = (r_cnt == L_FL) ? '0 : r_cnt + 1'b1;
         w_phase = r_phase ^ (r_cnt == L_FL);
      end else if (w_nxt == r_state)
         w_cnt = (r_state == HG && r_cnt == L_HG) ? r_cnt : r_cnt + 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= HG;
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_lamps <= 6'b001100;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt;
         r_phase <= w_phase;
         r_lamps <= lamps(w_nxt, w_phase);
      end
   end
   assign counter       = r_cnt;
   assign traffic_state = r_state;
   assign {H_R, H_Y, H_G, C_R, C_Y, C_G} = r_lamps;
endmodule

// File: tb/tb_traffic_ctrl_sensor.sv
// tb_traffic_ctrl_sensor: scoreboard bench for two controller configurations driven
// by the same directed and random sensor/flash stimulus.
module tb_traffic_ctrl_sensor;
   localparam int T_HY = 3, T_AR = 1, T_CG_MIN = 2, T_CY = 3, T_FL = 2;
   localparam int HG = 0, HY = 1, AR1 = 2, CG = 3, CY = 4, AR2 = 5, FL = 6;
   typedef struct {int st; int t;} mdl_t;
   typedef struct {int st; int cnt; logic [5:0] lamps;} exp_t;
   logic clk = 0, reset = 1, car_wait = 0, flash = 0;
   logic [3:0] a_cnt;
   logic [2:0] a_st, b_cnt, b_st;
   logic a_hr, a_hy, a_hg, a_cr, a_cy, a_cg;
   logic b_hr, b_hy, b_hg, b_cr, b_cy, b_cg;
   exp_t qa[$], qb[$];
   int n_vec = 0, n_bad = 0;
   mdl_t ma, mb;

   traffic_ctrl_sensor dut_a (
      .clk(clk), .reset(reset), .car_wait(car_wait), .flash(flash),
      .counter(a_cnt), .traffic_state(a_st),
      .H_R(a_hr), .H_Y(a_hy), .H_G(a_hg), .C_R(a_cr), .C_Y(a_cy), .C_G(a_cg));

   traffic_ctrl_sensor #(.CW(3), .T_HG(8), .T_CG_MAX(8)) dut_b (
      .clk(clk), .reset(reset), .car_wait(car_wait), .flash(flash),
      .counter(b_cnt), .traffic_state(b_st),
      .H_R(b_hr), .H_Y(b_hy), .H_G(b_hg), .C_R(b_cr), .C_Y(b_cy), .C_G(b_cg));

   always #5 clk = ~clk;

   // Model: phase name plus unbounded time spent in it; outputs derived from those.
   function automatic mdl_t nxt(mdl_t m, bit cw, bit fl, int thg, int tcgmax);
      mdl_t r = m;
      bit go;
      int seq[7] = '{HY, AR1, CG, CY, AR2, HG, AR2};
      if (fl) begin
         if (m.st == FL) r.t = m.t + 1;
         else begin r.st = FL; r.t = 0; end
         return r;
      end
      case (m.st)
         HG:       go = m.t >= thg - 1 && cw;
         HY:       go = m.t >= T_HY - 1;
         AR1, AR2: go = m.t >= T_AR - 1;
         CG:       go = m.t >= tcgmax - 1 || (m.t >= T_CG_MIN - 1 && !cw);
         CY:       go = m.t >= T_CY - 1;
         default:  go = 1;
      endcase
      if (go) begin r.st = seq[m.st]; r.t = 0; end
      else r.t = m.t + 1;
      return r;
   endfunction

   function automatic exp_t expect_of(mdl_t m, int thg);
      exp_t e;
      bit p = ((m.t / T_FL) % 2) == 0;
      e.st  = m.st;
      e.cnt = (m.st == HG && m.t > thg - 1) ? thg - 1 : (m.st == FL) ? m.t % T_FL : m.t;
      case (m.st)
         HG:       e.lamps = 6'b001100;
         HY:       e.lamps = 6'b010100;
         AR1, AR2: e.lamps = 6'b100100;
         CG:       e.lamps = 6'b100001;
         CY:       e.lamps = 6'b100010;
         default:  e.lamps = {1'b0, p, 2'b00, p, 1'b0};
      endcase
      return e;
   endfunction

   function automatic exp_t got_a();
      exp_t g;
      g.st = int'(a_st); g.cnt = int'(a_cnt);
      g.lamps = {a_hr, a_hy, a_hg, a_cr, a_cy, a_cg};
      return g;
   endfunction

   function automatic exp_t got_b();
      exp_t g;
      g.st = int'(b_st); g.cnt = int'(b_cnt);
      g.lamps = {b_hr, b_hy, b_hg, b_cr, b_cy, b_cg};
      return g;
   endfunction

   task automatic check(string nm, exp_t g, exp_t e);
      n_vec++;
      if (g.st != e.st || g.cnt != e.cnt || g.lamps !== e.lamps) begin
         n_bad++;
         $display("FAIL %s @%0t: got st=%0d cnt=%0d lamps=%b, want st=%0d cnt=%0d lamps=%b",
                  nm, $time, g.st, g.cnt, g.lamps, e.st, e.cnt, e.lamps);
      end
   endtask

   task automatic check_reset(string nm);
      exp_t e = '{st: HG, cnt: 0, lamps: 6'b001100};
      check({nm, "_a"}, got_a(), e);
      check({nm, "_b"}, got_b(), e);
   endtask

   task automatic rst_models();
      ma = '{st: HG, t: 0};
      mb = '{st: HG, t: 0};
   endtask

   // Drive one cycle of inputs and queue what each DUT must show after the edge.
   task automatic step(bit cw, bit fl);
      car_wait = cw;
      flash    = fl;
      ma = nxt(ma, cw, fl, 6, 8);
      mb = nxt(mb, cw, fl, 8, 8);
      qa.push_back(expect_of(ma, 6));
      qb.push_back(expect_of(mb, 8));
      @(posedge clk);
      #2;
   endtask

   task automatic wait_for(int st, int t, string nm);
      int k = 0;
      while (!(ma.st == st && ma.t == t) && k < 80) begin
         step(1, 0);
         k++;
      end
      if (k == 80) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: target phase not reached, got st=%0d want st=%0d", nm, ma.st, st);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) check("dut_a", got_a(), qa.pop_front());
      if (qb.size() > 0) check("dut_b", got_b(), qb.pop_front());
   end

   initial begin
      int fl_left = 0;
      rst_models();
      repeat (2) @(posedge clk);
      #2;
      check_reset("reset");
      reset = 0;
      repeat (20) step(0, 0);
      repeat (28) step(1, 0);
      repeat (30) step(!(ma.st == CG && ma.t >= 2), 0);
      repeat (30) step(ma.st != CG, 0);
      wait_for(CG, 3, "flash_entry");
      repeat (10) step(1, 1);
      repeat (6) step(1, 0);
      wait_for(HY, 1, "mid_hy");
      #2 reset = 1;
      qa.delete();
      qb.delete();
      #1 check_reset("async_reset");
      repeat (2) @(posedge clk);
      #2;
      reset = 0;
      rst_models();
      repeat (30) step(1, 0);
      repeat (600) begin
         if (fl_left > 0) fl_left--;
         else if ($urandom_range(0, 40) == 0) fl_left = $urandom_range(1, 8);
         step($urandom_range(0, 3) != 0, fl_left > 0);
      end
      for (int i = 0; i < 5 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
      if (qa.size() > 0 || qb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d entries left, want 0", qa.size() + qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/traffic_ctrl_sensor.md
Name: traffic_ctrl_sensor

Overview:
- Parametrised successor to the highway/country-road traffic-light FSM.
- Adds a country-road vehicle sensor, a minimum and maximum country green, all-red clearance intervals and a night flash mode.
- Timing durations and counter width are parameters.
- Sits at the intersection-controller level and drives the six lamp outputs directly; one instance per intersection.

Parameters:
- CW, 4, counter width in bits; every T_* must be 1..2^CW.
- T_HG, 6, minimum highway-green cycles.
- T_HY, 3, highway-yellow cycles.
- T_AR, 1, all-red clearance cycles, used for both AR states.
- T_CG_MIN, 2, minimum country-green cycles.
- T_CG_MAX, 8, maximum country-green cycles; must be >= T_CG_MIN.
- T_CY, 3, country-yellow cycles.
- T_FL, 2, flash half-period in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- car_wait  in  1  country-road vehicle sensor, synchronous to clk.
- flash  in  1  night flash-mode request, synchronous to clk.
- counter  out  CW  cycles spent in current state (or current flash phase).
- traffic_state  out  3  current state encoding.
- H_R, H_Y, H_G  out  1 each  highway lamps.
- C_R, C_Y, C_G  out  1 each  country lamps.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- State encodings:
  - HG=000, HY=001, AR1=010, CG=011, CY=100, AR2=101, FL=110.
  - 111 is unreachable; if ever entered, the next state is HG.
- Reset values: state=HG, counter=0, flash_phase=0, H_G=1, C_R=1, all other lamps 0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- All transitions are evaluated at the rising edge using the input values of the preceding cycle.
- Counter:
  - Zero on entry to any state.
  - Increments once per cycle while the state is held.
  - In HG it saturates at T_HG-1 and never wraps.
- Fixed-duration states: HY lasts T_HY cycles, AR1 and AR2 last T_AR cycles, CY lasts T_CY cycles. Each exits when counter==T-1.
- Transition sequence: HG -> HY -> AR1 -> CG -> CY -> AR2 -> HG.
- HG exit: leaves when counter==T_HG-1 and car_wait==1. With car_wait==0, HG holds indefinitely with counter at T_HG-1.
- CG exit: leaves for CY when either of these holds:
  - counter==T_CG_MAX-1, or
  - counter>=T_CG_MIN-1 and car_wait==0.
- Flash mode:
  - flash==1 has priority over every other transition: next state is FL from any state.
  - On entry to FL: counter=0, flash_phase=1.
  - While in FL: when counter==T_FL-1, counter goes to 0 and flash_phase toggles.
  - flash==0 while in FL: next state is AR2, then HG.
- Lamp decode (Moore, from the state register and flash_phase only):
  - HG: H_G, C_R.
  - HY: H_Y, C_R.
  - AR1, AR2: H_R, C_R.
  - CG: C_G, H_R.
  - CY: C_Y, H_R.
  - FL: H_Y=C_Y=flash_phase; all reds and greens 0.
- Invariants, checkable every cycle:
  - Exactly one lamp per road is lit, except in FL.
  - H_G & C_G is never 1.
  - A non-red lamp on one road implies red on the other, except in FL.

Test Plan:
- Idle highway: reset 2 cycles, car_wait=0 for 20 cycles -> state=000 throughout, counter runs 0..5 then holds 5; H_G=1, C_R=1.
- Full cycle: car_wait=1 from reset release -> HG 6 cycles, HY 3, AR1 1, CG 8 (max), CY 3, AR2 1, then HG with counter=0. Lamp decode checked in every state.
- Early country exit: car_wait drops to 0 in the third CG cycle (counter=2) -> CG lasts exactly 3 cycles, then CY. A drop at counter=0 still holds CG for 2 cycles (T_CG_MIN).
- Flash entry/exit: flash=1 during the 4th CG cycle -> next state 110; H_Y=C_Y toggle 1,1,0,0,1,1 every 2 cycles; reds and greens 0. flash=0 -> AR2 for 1 cycle, then HG.
- Async reset mid-HY: reset rises between clock edges -> state=000, counter=0, H_G=1, C_R=1 before the next edge. After release, normal sequencing resumes.
- Parameter sweep: CW=3, T_HG=8, T_CG_MAX=8 -> HG counter saturates at 7 without wrapping, and CG exits exactly at counter=7.
